// File: rtl/rx_buf_sched.sv
// Receive-side bank scheduler. It hands free raw-RAM banks to the MII capture writer,
// runs the parser over full banks oldest-first, and holds the payload RAM until the consumer acks.
module rx_buf_sched #(
  parameter int ADDR_W    = 9,
  parameter int NUM_BANKS = 2,
  parameter int BANK_W    = $clog2(NUM_BANKS),
  parameter int TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_done,
  output logic [BANK_W-1:0] cap_bank,
  output logic              cap_ready,
  output logic              parse_start,
  output logic [BANK_W-1:0] parse_bank,
  input  logic              parse_done,
  input  logic [ADDR_W-1:0] parse_last,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_last_addr,
  input  logic              out_ack,
  output logic [15:0]       frame_count,
  output logic [15:0]       drop_count,
  output logic [1:0]        state_dbg
);

  // Handshakes: a cap_done pulse is taken only while cap_ready=1 (otherwise it is an
  // overrun and is counted as a drop); out_valid rises with the payload, holds out_last_addr
  // stable, and falls on the edge after out_ack=1 is seen while it is high.

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PARSING = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;

  localparam int          CNT_W   = BANK_W + 1;
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  logic [1:0]           state;
  logic [NUM_BANKS-1:0] full_q;
  logic [NUM_BANKS-1:0] full_nxt;
  logic [BANK_W-1:0]    fifo_mem [NUM_BANKS];
  logic [BANK_W-1:0]    rd_ptr;
  logic [BANK_W-1:0]    wr_ptr;
  logic [CNT_W-1:0]     fifo_cnt;
  logic [15:0]          wd_cnt;

  logic              push;
  logic              pop;
  logic              overrun;
  logic              start;
  logic              accept;
  logic              wd_drop;
  logic [BANK_W-1:0] head_bank;
  logic [BANK_W-1:0] cap_bank_nxt;
  logic              cap_ready_nxt;
  logic [1:0]        drop_inc;
  logic [16:0]       drop_sum;

  assign state_dbg = state;
  assign head_bank = fifo_mem[rd_ptr];

  assign push    = cap_done && cap_ready;
  assign overrun = cap_done && !cap_ready;
  assign start   = (state == S_IDLE) && (fifo_cnt != '0) && !out_valid;
  assign accept  = (state == S_PARSING) && parse_done;
  assign wd_drop = (state == S_PARSING) && !parse_done && (wd_cnt == WD_LAST);
  assign pop     = accept || wd_drop;

  // The bank under capture is always free and the head is always full, so push and
  // pop in the same cycle never touch the same bit.
  always_comb begin
    full_nxt = full_q;
    if (push) full_nxt[cap_bank] = 1'b1;
    if (pop)  full_nxt[head_bank] = 1'b0;
  end

  // Lowest-index free bank of the next-cycle map, so a bank freed now is usable next cycle.
  always_comb begin
    cap_bank_nxt  = '0;
    cap_ready_nxt = 1'b0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (!full_nxt[i]) begin
        cap_bank_nxt  = BANK_W'(i);
        cap_ready_nxt = 1'b1;
      end
    end
  end

  assign drop_inc = {1'b0, overrun} + {1'b0, wd_drop};
  assign drop_sum = {1'b0, drop_count} + 17'(drop_inc);

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_mem[wr_ptr] <= cap_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      full_q        <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      fifo_cnt      <= '0;
      wd_cnt        <= '0;
      cap_bank      <= '0;
      cap_ready     <= 1'b1;
      parse_start   <= 1'b0;
      parse_bank    <= '0;
      out_valid     <= 1'b0;
      out_last_addr <= '0;
      frame_count   <= '0;
      drop_count    <= '0;
    end else begin
      full_q      <= full_nxt;
      cap_bank    <= cap_bank_nxt;
      cap_ready   <= cap_ready_nxt;
      drop_count  <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      parse_start <= 1'b0;

      if (push) wr_ptr <= wr_ptr + BANK_W'(1);
      if (pop)  rd_ptr <= rd_ptr + BANK_W'(1);

      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase

      case (state)
        S_IDLE: begin
          if (start) begin
            parse_bank  <= head_bank;
            parse_start <= 1'b1;
            wd_cnt      <= '0;
            state       <= S_PARSING;
          end
        end
        S_PARSING: begin
          wd_cnt <= wd_cnt + 16'd1;
          // A completion on the watchdog's last cycle still counts as a frame.
          if (accept) begin
            out_last_addr <= parse_last;
            out_valid     <= 1'b1;
            frame_count   <= (frame_count == 16'hFFFF) ? frame_count : frame_count + 16'd1;
            state         <= S_HOLD;
          end else if (wd_drop) begin
            state <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (out_ack) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
